// File: rtl/bep_frame_deserializer.sv
// Frame deserializer behind the Manchester decoder: shifts in ADDR, DATA and an even-parity bit,
// filters on node/broadcast address and strobes accepted payloads out with a one-cycle valid.
module bep_frame_deserializer #(
    parameter int                    ADDR_WIDTH     = 4,
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter logic [ADDR_WIDTH-1:0] BCAST_ADDR     = {ADDR_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  manchester_clock,
    input  logic                  manchester_data,
    input  logic                  transmission_begin,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] parallel_out,
    output logic                  valid,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int CNT_MAX = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    // Abort on the edge where tmo would reach TIMEOUT_CYCLES-1, hence the >= 2 constraint.
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        DATA   = 2'd2,
        PARITY = 2'd3
    } state_t;

    state_t                state;
    logic                  mc_q;
    logic                  bit_edge;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic [TMO_W-1:0]      tmo;
    logic                  parity_acc;
    logic                  addr_hit;

    assign bit_edge = manchester_clock & ~mc_q;
    assign addr_hit = (addr_reg == address) || (addr_reg == BCAST_ADDR);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mc_q         <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
            bit_cnt      <= '0;
            tmo          <= '0;
            parity_acc   <= 1'b0;
            parallel_out <= '0;
            valid        <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            mc_q        <= manchester_clock;
            valid       <= 1'b0;
            frame_error <= 1'b0;

            // A begin pulse always restarts, dropping any coincident bit and partial frame silently.
            if (transmission_begin) begin
                state      <= ADDR;
                bit_cnt    <= '0;
                tmo        <= '0;
                parity_acc <= 1'b0;
            end else if (state != IDLE) begin
                if (bit_edge) begin
                    tmo        <= '0;
                    parity_acc <= parity_acc ^ manchester_data;
                    case (state)
                        ADDR: begin
                            addr_reg <= {addr_reg[ADDR_WIDTH-2:0], manchester_data};
                            if (bit_cnt == ADDR_LAST) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        DATA: begin
                            data_reg <= {data_reg[DATA_WIDTH-2:0], manchester_data};
                            if (bit_cnt == DATA_LAST) begin
                                state   <= PARITY;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        PARITY: begin
                            state <= IDLE;
                            if (parity_acc ^ manchester_data) begin
                                frame_error <= 1'b1;
                            end else if (addr_hit) begin
                                parallel_out <= data_reg;
                                valid        <= 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end else if (tmo == TMO_LAST) begin
                    state       <= IDLE;
                    frame_error <= 1'b1;
                end else begin
                    tmo <= tmo + TMO_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bep_frame_deserializer.sv
// Self-checking bench for bep_frame_deserializer: table vectors, randomized frames against
// a frame-level reference model, and hand-written timeout/restart/reset sequences.
module tb_bep_frame_deserializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       manchester_clock;
    logic       manchester_data;
    logic       transmission_begin;
    logic [3:0] address;
    logic [7:0] parallel_out;
    logic       valid;
    logic       frame_error;
    logic       busy;

    int checks = 0;
    int fails = 0;
    int valid_seen = 0;
    int error_seen = 0;
    logic [7:0] model_out;

    bep_frame_deserializer #(
        .ADDR_WIDTH    (4),
        .DATA_WIDTH    (8),
        .TIMEOUT_CYCLES(16),
        .BCAST_ADDR    (4'hF)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .manchester_clock  (manchester_clock),
        .manchester_data   (manchester_data),
        .transmission_begin(transmission_begin),
        .address           (address),
        .parallel_out      (parallel_out),
        .valid             (valid),
        .frame_error       (frame_error),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] node;
        logic [3:0] a;
        logic [7:0] d;
        logic       flip;
        logic       exp_valid;
        logic       exp_error;
        logic [7:0] exp_out;
    } vec_t;

    // Strobe exclusivity is checked whenever either strobe fires.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (valid || frame_error)) begin
            if (valid) valid_seen++;
            if (frame_error) error_seen++;
            checks++;
            if (valid && frame_error) begin
                fails++;
                $display("[TB] FAIL strobe_exclusive: got valid=1 frame_error=1, expected at most one high");
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic even_parity(input logic [3:0] a, input logic [7:0] d);
        return ^{a, d};
    endfunction

    task automatic send_bit(input logic b, input int gap);
        manchester_data  = b;
        manchester_clock = 1'b1;
        tick();
        manchester_clock = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic start_frame;
        transmission_begin = 1'b1;
        tick();
        transmission_begin = 1'b0;
    endtask

    // Sends one frame and returns the strobes seen in the cycle after the parity bit is consumed.
    task automatic applyStimulus(input logic [3:0] node, input logic [3:0] a, input logic [7:0] d,
                                 input logic flip, input int gap, input bit skip_begin,
                                 input bit chain, input string tag,
                                 output logic got_valid, output logic got_error,
                                 output logic [7:0] got_out);
        logic [11:0] bits;
        bits    = {a, d};
        address = node;
        if (!skip_begin) start_frame();
        for (int i = 0; i < 12; i++) send_bit(bits[11-i], gap);
        manchester_data  = even_parity(a, d) ^ flip;
        manchester_clock = 1'b1;
        tick();
        manchester_clock = 1'b0;
        @(negedge clk);
        got_valid = valid;
        got_error = frame_error;
        got_out   = parallel_out;
        if (chain) transmission_begin = 1'b1;
        tick();
        transmission_begin = 1'b0;
        @(negedge clk);
        checkOutput({tag, " valid_width"}, 32'(valid), 32'd0);
        checkOutput({tag, " error_width"}, 32'(frame_error), 32'd0);
        if (!chain) checkOutput({tag, " busy_after"}, 32'(busy), 32'd0);
    endtask

    // Model-checked frame: expected outcome derived from the parity and address rules.
    task automatic model_frame(input logic [3:0] node, input logic [3:0] a, input logic [7:0] d,
                               input logic flip, input int gap, input bit skip_begin,
                               input bit chain, input string tag);
        logic gv, ge, ev;
        logic [7:0] go;
        ev = !flip && (a == node || a == 4'hF);
        if (ev) model_out = d;
        applyStimulus(node, a, d, flip, gap, skip_begin, chain, tag, gv, ge, go);
        checkOutput({tag, " valid"}, 32'(gv), 32'(ev));
        checkOutput({tag, " frame_error"}, 32'(ge), 32'(flip));
        checkOutput({tag, " parallel_out"}, 32'(go), 32'(model_out));
    endtask

    initial begin
        #500000;
        fails++;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        vec_t vecs[8];
        logic gv, ge;
        logic [7:0] go;
        int found, v0, e0;
        logic [3:0] rn, ra;
        logic [7:0] rd;
        logic rf;

        vecs[0] = '{4'h3, 4'h3, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5};
        vecs[1] = '{4'h3, 4'h5, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[2] = '{4'h3, 4'hF, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C};
        vecs[3] = '{4'h3, 4'h3, 8'h01, 1'b1, 1'b0, 1'b1, 8'h3C};
        vecs[4] = '{4'h7, 4'h7, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[5] = '{4'h3, 4'hF, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[6] = '{4'h0, 4'h0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF};
        vecs[7] = '{4'hC, 4'h3, 8'h81, 1'b0, 1'b0, 1'b0, 8'hFF};

        rst_n              = 1'b0;
        manchester_clock   = 1'b0;
        manchester_data    = 1'b0;
        transmission_begin = 1'b0;
        address            = 4'h3;
        tick();
        checkOutput("reset parallel_out", 32'(parallel_out), 32'd0);
        checkOutput("reset valid", 32'(valid), 32'd0);
        checkOutput("reset frame_error", 32'(frame_error), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        model_out = 8'h00;

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].node, vecs[i].a, vecs[i].d, vecs[i].flip, 1 + (i % 3), 1'b0, 1'b0,
                          $sformatf("vec%0d", i), gv, ge, go);
            checkOutput($sformatf("vec%0d valid", i), 32'(gv), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d frame_error", i), 32'(ge), 32'(vecs[i].exp_error));
            checkOutput($sformatf("vec%0d parallel_out", i), 32'(go), 32'(vecs[i].exp_out));
            model_out = vecs[i].exp_out;
        end

        $display("[TB] timeout after 6 bits");
        address = 4'h3;
        start_frame();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1);
        manchester_data  = 1'b0;
        manchester_clock = 1'b1;
        tick();
        manchester_clock = 1'b0;
        found = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            @(negedge clk);
            if (frame_error) begin
                found = k;
                checkOutput("timeout busy", 32'(busy), 32'd0);
                checkOutput("timeout valid", 32'(valid), 32'd0);
                break;
            end
        end
        checkOutput("timeout latency", 32'(found), 32'd15);
        model_frame(4'h3, 4'h3, 8'h96, 1'b0, 2, 1'b0, 1'b0, "after_timeout");

        $display("[TB] longest legal bit gap");
        model_frame(4'h3, 4'h3, 8'h6D, 1'b0, 14, 1'b0, 1'b0, "gap14");

        $display("[TB] restart mid-frame");
        v0 = valid_seen;
        e0 = error_seen;
        start_frame();
        for (int i = 0; i < 7; i++) send_bit((i < 2) ? 1'b0 : 1'b1, 1);
        model_frame(4'h3, 4'h3, 8'h42, 1'b0, 1, 1'b0, 1'b0, "restart");
        checkOutput("restart valid_count", 32'(valid_seen - v0), 32'd1);
        checkOutput("restart error_count", 32'(error_seen - e0), 32'd0);

        $display("[TB] begin with coincident bit edge");
        transmission_begin = 1'b1;
        manchester_data    = 1'b1;
        manchester_clock   = 1'b1;
        tick();
        transmission_begin = 1'b0;
        manchester_clock   = 1'b0;
        tick();
        model_frame(4'h3, 4'h3, 8'h5A, 1'b0, 1, 1'b1, 1'b0, "begin_edge");

        $display("[TB] back-to-back frames");
        model_frame(4'h3, 4'h3, 8'h11, 1'b0, 1, 1'b0, 1'b1, "b2b_first");
        model_frame(4'h3, 4'hF, 8'h22, 1'b0, 1, 1'b1, 1'b0, "b2b_second");

        $display("[TB] randomized frames");
        for (int i = 0; i < 24; i++) begin
            rn = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 2) == 0) ? rn : 4'($urandom_range(0, 15));
            rd = 8'($urandom);
            rf = ($urandom_range(0, 3) == 0);
            model_frame(rn, ra, rd, rf, $urandom_range(1, 4), 1'b0, 1'b0, $sformatf("rand%0d", i));
        end

        $display("[TB] async reset mid-DATA");
        model_frame(4'h3, 4'h3, 8'hC3, 1'b0, 1, 1'b0, 1'b0, "pre_reset");
        start_frame();
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset parallel_out", 32'(parallel_out), 32'd0);
        checkOutput("async_reset valid", 32'(valid), 32'd0);
        checkOutput("async_reset frame_error", 32'(frame_error), 32'd0);
        checkOutput("async_reset busy", 32'(busy), 32'd0);
        model_out = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        model_frame(4'h3, 4'h3, 8'h7E, 1'b0, 2, 1'b0, 1'b0, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
